// File: rtl/customized_to_fixed_converter.sv
// rtl/customized_to_fixed_converter.sv - customized float to sign-magnitude fixed-point, one alignment bit per cycle
module customized_to_fixed_converter #(
    parameter int int_len      = 8,
    parameter int fra_len      = 4,
    parameter int montissa_len = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [montissa_len+8:0]   ieee_val,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [int_len-1:0]        o_integer,
    output logic [fra_len-1:0]        o_fraction,
    output logic                      sign_flag,
    output logic                      overflow
);

    localparam int W  = int_len + fra_len;
    localparam int AW = (W > montissa_len + 1) ? W : montissa_len + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, next_state;
    logic [AW-1:0]      acc, acc_next;
    logic signed [15:0] cnt, cnt_next;
    logic               sign_r, sign_next;
    logic               ovf_r, ovf_next;

    logic               sign_in;
    logic [7:0]         exp_in;
    logic [montissa_len-1:0] man_in;
    logic [AW-1:0]      m_ext, sat_val;
    logic signed [15:0] e_val, s_val;

    assign sign_in = ieee_val[montissa_len+8];
    assign exp_in  = ieee_val[montissa_len+7:montissa_len];
    assign man_in  = ieee_val[montissa_len-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            sign_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            state  <= next_state;
            acc    <= acc_next;
            cnt    <= cnt_next;
            sign_r <= sign_next;
            ovf_r  <= ovf_next;
        end
    end

    always_comb begin
        next_state = state;
        acc_next   = acc;
        cnt_next   = cnt;
        sign_next  = sign_r;
        ovf_next   = ovf_r;

        m_ext                   = '0;
        m_ext[montissa_len:0]   = {1'b1, man_in};
        sat_val                 = '0;
        sat_val[W-1:0]          = '1;
        e_val = $signed({8'b0, exp_in}) - 16'sd127;
        s_val = e_val - 16'(montissa_len) + 16'(fra_len);

        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_next  = sign_in;
                    ovf_next   = 1'b0;
                    cnt_next   = '0;
                    next_state = DONE;
                    if (exp_in == 8'd0) begin
                        acc_next = '0;
                    end else if (exp_in == 8'hFF || e_val >= 16'(int_len)) begin
                        acc_next = sat_val;
                        ovf_next = 1'b1;
                    end else if (e_val < -16'(fra_len)) begin
                        acc_next = '0;
                    end else begin
                        // In range: the aligned value is known to fit in W bits.
                        acc_next = m_ext;
                        cnt_next = s_val;
                        if (s_val != 16'sd0)
                            next_state = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (cnt > 16'sd0) begin
                    acc_next = acc << 1;
                    cnt_next = cnt - 16'sd1;
                end else if (cnt < 16'sd0) begin
                    acc_next = acc >> 1;
                    cnt_next = cnt + 16'sd1;
                end
                if (cnt_next == 16'sd0)
                    next_state = DONE;
            end
            DONE: begin
                if (out_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign o_integer  = acc[W-1:fra_len];
    assign o_fraction = acc[fra_len-1:0];
    assign sign_flag  = sign_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_customized_to_fixed_converter.sv
// tb/tb_customized_to_fixed_converter.sv - scoreboard bench for customized_to_fixed_converter
module tb_customized_to_fixed_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ieee_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  o_integer;
    logic [3:0]  o_fraction;
    logic        sign_flag;
    logic        overflow;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [31:0] ieee_val2 = '0;
    logic        out_valid2;
    logic [16:0] o_integer2;
    logic [3:0]  o_fraction2;
    logic        sign_flag2;
    logic        overflow2;

    customized_to_fixed_converter #(.int_len(8), .fra_len(4), .montissa_len(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ieee_val(ieee_val),
        .out_valid(out_valid), .out_ready(out_ready), .o_integer(o_integer),
        .o_fraction(o_fraction), .sign_flag(sign_flag), .overflow(overflow)
    );

    customized_to_fixed_converter #(.int_len(17), .fra_len(4), .montissa_len(23)) dut17 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .ieee_val(ieee_val2),
        .out_valid(out_valid2), .out_ready(1'b1), .o_integer(o_integer2),
        .o_fraction(o_fraction2), .sign_flag(sign_flag2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ei;
        logic [3:0] ef;
        logic       sg;
        logic       ov;
        int         lat;
        int         acc_cyc;
    } exp_t;

    exp_t q[$];
    int   cycle = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Monitor: samples mid-low-phase, after the bench has driven its inputs.
    logic       prev_valid = 1'b0;
    int         first_cyc = 0;
    logic [7:0] snap_i;
    logic [3:0] snap_f;
    logic       snap_s, snap_o;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    first_cyc = cycle;
                    snap_i = o_integer; snap_f = o_fraction;
                    snap_s = sign_flag; snap_o = overflow;
                end else if (out_valid) begin
                    chk("hold_integer", o_integer, snap_i);
                    chk("hold_fraction", o_fraction, snap_f);
                    chk("hold_sign", sign_flag, snap_s);
                    chk("hold_in_ready", in_ready, 1'b0);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_output actual=%0h required=none", {o_integer, o_fraction});
                    end else begin
                        e = q.pop_front();
                        chk("integer", o_integer, e.ei);
                        chk("fraction", o_fraction, e.ef);
                        chk("sign", sign_flag, e.sg);
                        chk("overflow", overflow, e.ov);
                        chk("latency", first_cyc - e.acc_cyc + 1, e.lat);
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [7:0] ei, input logic [3:0] ef,
                        input logic sg, input logic ov, input int lat);
        exp_t e;
        wait_ready();
        e.ei = ei; e.ef = ef; e.sg = sg; e.ov = ov; e.lat = lat; e.acc_cyc = cycle + 1;
        q.push_back(e);
        ieee_val = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    task automatic send2(input logic [31:0] w, input logic [16:0] ei, input logic [3:0] ef,
                         input logic ov, input int lat);
        int n;
        @(negedge clk);
        ieee_val2 = w;
        in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        n = 1;
        while (!out_valid2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("w17_integer", o_integer2, ei);
        chk("w17_fraction", o_fraction2, ef);
        chk("w17_overflow", overflow2, ov);
        chk("w17_latency", n, lat);
        @(negedge clk);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_integer", o_integer, 8'd0);
        chk("rst_fraction", o_fraction, 4'd0);
        chk("rst_sign", sign_flag, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        send(32'h41420000, 8'd12,   4'b0010, 1'b0, 1'b0, 17);
        send(32'hC1420000, 8'd12,   4'b0010, 1'b1, 1'b0, 17);
        send(32'h43800000, 8'hFF,   4'hF,    1'b0, 1'b1, 1);
        send(32'h7F800000, 8'hFF,   4'hF,    1'b0, 1'b1, 1);
        send(32'h00000000, 8'h00,   4'h0,    1'b0, 1'b0, 1);
        send(32'h00000001, 8'h00,   4'h0,    1'b0, 1'b0, 1);
        send(32'h3D000000, 8'h00,   4'h0,    1'b0, 1'b0, 1);
        send(32'h80000000, 8'h00,   4'h0,    1'b1, 1'b0, 1);
        send(32'h3F800000, 8'd1,    4'h0,    1'b0, 1'b0, 20);
        send(32'h3D800000, 8'd0,    4'h1,    1'b0, 1'b0, 24);
        send(32'h437FF000, 8'hFF,   4'hF,    1'b0, 1'b0, 13);
        drain();

        // Stall in DONE, with a stray word offered that must be ignored.
        out_ready = 1'b0;
        send(32'h41420000, 8'd12, 4'b0010, 1'b0, 1'b0, 17);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk("stall_out_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                ieee_val = 32'h43800000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", in_ready, 1'b1);
        send(32'h3F800000, 8'd1, 4'h0, 1'b0, 1'b0, 20);
        drain();

        // Reset mid-SHIFT, then a clean conversion.
        wait_ready();
        ieee_val = 32'h41420000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_integer", o_integer, 8'd0);
        chk("midrst_fraction", o_fraction, 4'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        send(32'h41420000, 8'd12, 4'b0010, 1'b0, 1'b0, 17);
        drain();

        send2(32'h47800060, 17'd65536, 4'b1100, 1'b0, 4);
        send2(32'h48000000, 17'h1FFFF, 4'hF,    1'b1, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        total_cnt++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/customized_to_fixed_converter.md
Name: customized_to_fixed_converter

Overview:
Inverse of the fixed-to-float converter. Takes a customized float word (sign, 8-bit exponent with bias 127, parametrised mantissa) and returns a sign-magnitude fixed-point value split into integer and fraction fields. Results from the customized multiplier or add/sub feed it on their way back to fixed-point consumers. It aligns the mantissa iteratively, one bit per cycle, behind a valid/ready handshake on both sides.

Parameters:
int_len, 8, width of integer output field
fra_len, 4, width of fraction output field
montissa_len, 23, stored mantissa width; input word width is montissa_len+9

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  ieee_val is valid
in_ready  output  1  block can accept a word (high only in IDLE)
ieee_val  input  montissa_len+9  {sign, exp[7:0], mantissa[montissa_len-1:0]}
out_valid  output  1  result fields valid
out_ready  input  1  consumer accepts the result
o_integer  output  int_len  magnitude, integer part
o_fraction  output  fra_len  magnitude, fraction part
sign_flag  output  1  copy of the input sign bit
overflow  output  1  magnitude saturated

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; o_integer=0, o_fraction=0, sign_flag=0, overflow=0; working registers cleared.
- Definitions: W=int_len+fra_len; e=exp-127; m={1'b1,mantissa}; s=e-montissa_len+fra_len (signed shift count).
- Result: {o_integer,o_fraction} = floor(|value|·2^fra_len). Truncation toward zero; no rounding.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. An accept (in_valid&&in_ready) latches sign and classifies the word. Next state:
  - exp==0 (zero/denormal): result 0, overflow=0, go to DONE.
  - exp==255: saturate, overflow=1, go to DONE.
  - e>=int_len: saturate, overflow=1, go to DONE.
  - e< -fra_len: result 0, overflow=0, go to DONE.
  - s==0: acc=m, go to DONE.
  - otherwise: acc=m, cnt=s, go to SHIFT.
- Saturate means all ones in both o_integer and o_fraction.
- SHIFT: one bit per cycle. If cnt>0, acc<<=1 and cnt-=1. If cnt<0, acc>>=1 and cnt+=1. Go to DONE in the cycle cnt reaches 0.
- Internal acc width is max(W, montissa_len+1). The in-range classification guarantees the final acc < 2^W, so no overflow is checked during SHIFT.
- DONE: out_valid=1. Outputs are registered and held stable while out_valid && !out_ready. out_ready moves the state to IDLE; out_valid drops the next cycle.
- in_ready=0 in SHIFT and DONE. A new word can be accepted no earlier than the cycle after the handshake.
- Latency, accept edge to out_valid: special or clamped cases = 1 cycle; otherwise |s|+1 cycles.
- Sign is passed through unchanged, including for zero and saturated results.
- in_valid in a non-IDLE state is ignored; the word is not latched.

Test Plan:
- int_len=17, fra_len=4, ieee_val=0x47800060 (65536.75) -> after 4 cycles: o_integer=65536, o_fraction=4'b1100, sign_flag=0, overflow=0.
- int_len=8, fra_len=4, ieee_val=0x41420000 (12.125) -> after 17 cycles: o_integer=12, o_fraction=4'b0010. With 0xC1420000: same magnitude, sign_flag=1.
- int_len=8: 0x43800000 (256.0) -> 1-cycle latency, o_integer=8'hFF, o_fraction=4'hF, overflow=1. 0x7F800000 (inf) -> same.
- 0x00000000, 0x00000001 (denormal), 0x3D000000 (0.03125, e=-5<-4) -> all give zero outputs, overflow=0, 1-cycle latency.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout. Pulse in_valid with another word during DONE -> it is ignored. Release out_ready -> IDLE; back-to-back accept the following cycle.
- Assert rst in mid-SHIFT on the 12.125 case -> out_valid=0 and outputs zero immediately; in_ready=1 after release; the next conversion is correct.
